// File: rtl/arith_pkg.sv
// Shared state encodings and default width for the sequenced arithmetic blocks.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: difference = a - b - cin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic difference,
    output logic borrow
);

    assign difference = a ^ b ^ cin;
    assign borrow     = (~a & b) | (~(a ^ b) & cin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial a - b - bin: one full_subtractor cell is reused over WIDTH cycles, LSB first.
// Result flags are registered on entry to DONE and held until the next completed operation.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | ready for a new operation; start loads operands
//   ST_BUSY | one bit processed per edge, cnt tracks the bit index
//   ST_DONE | one-cycle done pulse; diff/bout/zero just updated
module serial_subtract_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   diff_sh_q, diff_sh_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               zero_q, zero_d;

    logic               fs_diff;
    logic               fs_borrow;

    full_subtractor u_fs (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .cin        (brw_q),
        .difference (fs_diff),
        .borrow     (fs_borrow)
    );

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        brw_d     = brw_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        zero_d    = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    brw_d     = bin;
                    cnt_d     = '0;
                    diff_sh_d = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                diff_sh_d = {fs_diff, diff_sh_q[WIDTH-1:1]};
                a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
                brw_d     = fs_borrow;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    diff_d  = diff_sh_d;
                    bout_d  = fs_borrow;
                    zero_d  = ~|diff_sh_d;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            brw_q     <= 1'b0;
            cnt_q     <= '0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            brw_q     <= brw_d;
            cnt_q     <= cnt_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            zero_q    <= zero_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_BUSY);
    assign done  = (state_q == ST_DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign zero  = zero_q;

endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
- Bit-serial N-bit subtractor controller: computes a - b - bin by time-sharing one full_subtractor cell over WIDTH cycles, LSB first.
- Sits beside the existing full_subtractor cell as the first sequenced arithmetic block in the basic-designs set.
- Trades area for latency.
- Simple start/ready/done handshake; result and flags held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit-index counter (derived; not overridden).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request a subtraction; accepted only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- ready  output  1  high in IDLE only.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned).
- zero  output  1  diff == 0; valid when done=1 and held afterwards.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; ready=1, busy=0, done=0, diff=0, bout=0, zero=0. Counter, shift registers and borrow register cleared. Reset overrides start and aborts any in-progress operation; no done pulse for an aborted operation.
- States: IDLE, BUSY, DONE. Encodings are 2-bit constants.
- IDLE:
  - start=1 at edge k: load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, diff shift reg<=0; go to BUSY.
  - start=0: stay in IDLE.
- BUSY:
  - Each edge drives full_subtractor with (a_sh[0], b_sh[0], brw).
  - Its difference is shifted into diff_sh at the MSB end (right shift); brw<=borrow.
  - a_sh and b_sh shift right by 1; cnt increments.
  - On the edge where cnt==WIDTH-1, the last bit is processed, cnt is cleared, and the state goes to DONE.
  - Bits are processed at edges k+1..k+WIDTH.
- DONE:
  - Lasts exactly one cycle. done=1; diff, bout and zero are registered and valid.
  - Next edge: IDLE unconditionally. start is ignored in DONE.
- Latency: start sampled at edge k; done visible in the cycle after edge k+WIDTH. Next accept is possible at edge k+WIDTH+2.
- start while BUSY or DONE: ignored; no queuing; operand inputs ignored.
- diff, bout and zero update only on entry to DONE. They hold through IDLE until the next DONE. They are not cleared by a new start.
- Arithmetic: per-bit diff=a^b^brw, borrow=(~a&b)|(~(a^b)&brw). No sign interpretation; bout is the unsigned underflow flag.
- busy = (state==BUSY); ready = (state==IDLE). Both are derived from registered state (glitch-free, no combinational path from inputs).

Decomposition:
- Shared package/header (arith_pkg): state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2; default WIDTH constant.
- Sub-module: one instance of the existing full_subtractor cell (ports: difference, borrow, a, b, cin), driven combinationally from the shift-register LSBs and the borrow register.
- No other hierarchy.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start 1 cycle -> ready drops next cycle, busy high 8 cycles, done pulse 1 cycle, diff=0x1E, bout=0, zero=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, zero=0; done exactly 8 cycles after the start edge.
- a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, zero=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Start 0x80-0x01, then assert start with a=0xFF, b=0xFF during BUSY and DONE -> ignored; result diff=0x7F, bout=0; exactly one done pulse.
- rst_n=0 for one edge at the 4th bit of a BUSY op -> next cycle ready=1, busy=0, diff=0, bout=0, zero=0; no done pulse. A following start with 0x03-0x05 -> diff=0xFE, bout=1.
- Back-to-back: start held high continuously with changing operands -> each operation accepted only when ready=1; the pattern done, one IDLE cycle, accept repeats; exhaustively compare 256 random pairs against a - b - bin.
